// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state and select encodings for the two-way bus arbiter
package mux_arb_pkg;

    // Arbiter FSM state; kept as plain constants so older netlists and probes see fixed codes
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t G0   = 2'd1;
    localparam state_t G1   = 2'd2;

    // Mux select encoding of the existing 2:1 datapath
    localparam logic SEL_REQ0 = 1'b1;
    localparam logic SEL_REQ1 = 1'b0;

    // Grant state owned by requester index `who` (0 -> G0, 1 -> G1)
    function automatic state_t grant_state(input logic who);
        return who ? G1 : G0;
    endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// rtl/mux_bus_arbiter_if.sv - requester, downstream and grant signals of the shared mux bus
interface mux_bus_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] din0;
    logic             req1;
    logic [WIDTH-1:0] din1;
    logic             out_ready;

    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    // Requesters and downstream sink drive this side
    modport master (
        output req0, din0, req1, din1, out_ready,
        input  gnt0, gnt1, sel, dout, dout_valid
    );

    // The arbiter itself
    modport slave (
        input  req0, din0, req1, din1, out_ready,
        output gnt0, gnt1, sel, dout, dout_valid
    );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick_valid,
    output logic pick
);

    // Contested: favour the side that was not served last; otherwise take whoever asks
    always_comb begin
        pick_valid = req0 | req1;
        if (req0 && req1) begin
            pick = ~last;
        end else begin
            pick = req1;
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - round-robin burst arbiter driving a shared 2:1 mux and output register
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    mux_bus_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic [CW-1:0]    beat_cnt;
    logic             retake;
    logic             retake_nx;
    logic             sel_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    logic             granted;
    logic             owner;
    logic             req_own;
    logic             beat;
    logic             rel_drop;
    logic             rel_done;
    logic             release_now;
    logic             pick_last;
    logic             pick_valid;
    logic             pick;
    logic [WIDTH-1:0] mux_out;

    assign granted = (state == G0) || (state == G1);
    assign owner   = (state == G1);
    assign req_own = owner ? bus.req1 : bus.req0;

    // A retake cycle follows a full burst re-granted to the same side and carries no beat
    assign beat        = granted && req_own && bus.out_ready && !retake;
    assign rel_drop    = granted && !req_own;
    assign rel_done    = beat && (beat_cnt == LAST_BEAT);
    assign release_now = rel_drop || rel_done;

    // While granted, the releasing owner is the effective "last" so the other side wins a tie
    assign pick_last = granted ? owner : last;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last       (pick_last),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // Next-state: arbitrate from IDLE or on release, otherwise keep the current grant
    always_comb begin
        state_nx = state;
        if (!granted || release_now) begin
            state_nx = pick_valid ? grant_state(pick) : IDLE;
        end
        retake_nx = rel_done && (state_nx == state);
    end

    // Grant state, round-robin pointer, burst counter and registered select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
            retake   <= 1'b0;
            sel_q    <= SEL_REQ1;
        end else begin
            state  <= state_nx;
            retake <= retake_nx;
            sel_q  <= (state_nx == G0) ? SEL_REQ0 : SEL_REQ1;
            if (release_now) begin
                last     <= owner;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    // The shared 2:1 mux; only the granted side is ever captured
    assign mux_out = (sel_q == SEL_REQ0) ? bus.din0 : bus.din1;

    // Output register: capture on a beat, hold otherwise; valid is a one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= beat;
            if (beat) begin
                dout_q <= mux_out;
            end
        end
    end

    assign bus.gnt0       = (state == G0);
    assign bus.gnt1       = (state == G1);
    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb/tb_mux_bus_arbiter.sv - scoreboard bench for the round-robin mux bus arbiter
module tb_mux_bus_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    string tname;
    logic [7:0] exp_q[$];

    mux_bus_arbiter_if #(.WIDTH(8)) bus ();

    mux_bus_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h at %0t", tname, name, act, exp, $time);
        end
    endtask

    // Monitor: every presented beat must match the next expected beat in order
    always @(negedge clk) begin
        if (!reset && bus.dout_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s/unexpected_beat: got %h expected no beat at %0t", tname, bus.dout, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    errors++;
                    $display("FAIL %s/beat_data: got %h expected %h at %0t", tname, bus.dout, e, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [7:0] d0, input logic r1,
                         input logic [7:0] d1, input logic rdy);
        bus.req0      = r0;
        bus.din0      = d0;
        bus.req1      = r1;
        bus.din1      = d1;
        bus.out_ready = rdy;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One cycle: check the grant seen now, drive inputs, queue the beat expected this cycle
    task automatic cyc(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                       input logic rdy, input logic [1:0] eg, input logic eb);
        chk("gnt0", 8'(bus.gnt0), 8'(eg[1]));
        chk("gnt1", 8'(bus.gnt1), 8'(eg[0]));
        chk("sel",  8'(bus.sel),  8'(eg[1]));
        drive(r0, d0, r1, d1, rdy);
        if (eb) exp_q.push_back(eg[1] ? d0 : d1);
        step();
    endtask

    task automatic drain();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (2) step();
        chk("drain", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        tname  = "reset";
        reset_dut();
        chk("gnt0", 8'(bus.gnt0), 8'd0);
        chk("gnt1", 8'(bus.gnt1), 8'd0);
        chk("sel",  8'(bus.sel), 8'd0);
        chk("dout", bus.dout, 8'h00);
        chk("dout_valid", 8'(bus.dout_valid), 8'd0);

        // Single requester, three beats then drop
        tname = "single";
        cyc(1, 8'h11, 0, 8'h00, 1, 2'b00, 0);
        cyc(1, 8'h11, 0, 8'h00, 1, 2'b10, 1);
        cyc(1, 8'h11, 0, 8'h00, 1, 2'b10, 1);
        cyc(1, 8'h11, 0, 8'h00, 1, 2'b10, 1);
        cyc(0, 8'h11, 0, 8'h00, 1, 2'b10, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 2'b00, 0);
        drain();

        // Both requesting from reset: four beats each, zero-gap handover
        tname = "contend";
        reset_dut();
        for (int k = 0; k <= 10; k++) begin
            logic [1:0] eg;
            eg = (k == 0) ? 2'b00 : ((k >= 5 && k <= 8) ? 2'b01 : 2'b10);
            cyc(k <= 9, 8'(8'hA0 + k), k <= 9, 8'(8'hB0 + k), 1, eg, (k >= 1 && k <= 9));
        end
        cyc(0, 8'h00, 0, 8'h00, 1, 2'b00, 0);
        drain();

        // Backpressure mid-burst: count frozen, dout held
        tname = "stall";
        reset_dut();
        for (int k = 0; k <= 12; k++) begin
            logic rdy;
            rdy = !(k >= 3 && k <= 7);
            if (k >= 4 && k <= 8) begin
                chk("hold_dout", bus.dout, 8'hC2);
                chk("hold_valid", 8'(bus.dout_valid), 8'd0);
            end
            cyc(k <= 11, 8'(8'hC0 + k), 0, 8'h00, rdy, (k == 0) ? 2'b00 : 2'b10,
                (k == 1 || k == 2 || k == 8 || k == 9 || k == 11));
        end
        cyc(0, 8'h00, 0, 8'h00, 1, 2'b00, 0);
        drain();

        // Single requester streaming past MAX_BURST: one retake gap per burst
        tname = "stream";
        reset_dut();
        for (int k = 0; k <= 12; k++) begin
            cyc(0, 8'h00, k <= 11, 8'(8'h40 + k), 1, (k == 0) ? 2'b00 : 2'b01,
                (k >= 1 && k <= 11 && k != 5 && k != 10));
        end
        cyc(0, 8'h00, 0, 8'h00, 1, 2'b00, 0);
        drain();

        // Asynchronous reset in the second beat of a G1 burst
        tname = "async_reset";
        reset_dut();
        cyc(1, 8'h51, 0, 8'h00, 1, 2'b00, 0);
        cyc(1, 8'h52, 0, 8'h00, 1, 2'b10, 1);
        cyc(0, 8'h00, 1, 8'h62, 1, 2'b10, 0);
        cyc(0, 8'h00, 1, 8'h63, 1, 2'b01, 0);
        drive(1'b0, 8'h00, 1'b1, 8'h64, 1'b1);
        chk("pre_gnt1", 8'(bus.gnt1), 8'd1);
        chk("pre_dout", bus.dout, 8'h63);
        chk("pre_valid", 8'(bus.dout_valid), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_gnt1", 8'(bus.gnt1), 8'd0);
        chk("rst_gnt0", 8'(bus.gnt0), 8'd0);
        chk("rst_valid", 8'(bus.dout_valid), 8'd0);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_sel", 8'(bus.sel), 8'd0);
        reset_dut();
        cyc(1, 8'h71, 1, 8'h81, 1, 2'b00, 0);
        cyc(1, 8'h72, 1, 8'h82, 1, 2'b10, 1);
        cyc(0, 8'h73, 1, 8'h83, 1, 2'b10, 0);
        cyc(0, 8'h74, 1, 8'h84, 1, 2'b01, 1);
        cyc(0, 8'h00, 0, 8'h00, 1, 2'b01, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 2'b00, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
